// File: rtl/pipeline_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_sequencer_if
// Purpose  : Control/status and stage start/done bundle of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface pipeline_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             continuous;
  logic             trigger;
  logic             err_clr;
  logic             samples_valid;
  logic             fft_done;
  logic             fe_done;
  logic             nn_done;
  logic             fft_start;
  logic             fe_start;
  logic             nn_start;
  logic             frame_done;
  logic             busy;
  logic             overrun;
  logic             timeout;
  logic [1:0]       err_stage;
  logic [CNT_W-1:0] frame_count;
  logic [2:0]       state;

  modport master (
    input  enable, continuous, trigger, err_clr, samples_valid,
           fft_done, fe_done, nn_done,
    output fft_start, fe_start, nn_start, frame_done, busy,
           overrun, timeout, err_stage, frame_count, state
  );

  modport slave (
    output enable, continuous, trigger, err_clr, samples_valid,
           fft_done, fe_done, nn_done,
    input  fft_start, fe_start, nn_start, frame_done, busy,
           overrun, timeout, err_stage, frame_count, state
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_sequencer
// Purpose  : Per-frame FFT -> FE -> NN sequencer; optional per-stage watchdog
//            built when PIPELINE_SEQ_WDT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_sequencer #(
  parameter int WDT_CYCLES = 4096,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_sequencer_if.master seq_if
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_FFT   = 3'd2,
    ST_FE    = 3'd3,
    ST_NN    = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  if (WDT_CYCLES < 2) begin : g_wdt_param_check
    $error("pipeline_sequencer: WDT_CYCLES must be at least 2");
  end

  state_e           state_q, state_d;
  logic             sv_q;
  logic             fft_start_q, fft_start_d;
  logic             fe_start_q,  fe_start_d;
  logic             nn_start_q,  nn_start_d;
  logic             overrun_q;
  logic [CNT_W-1:0] frame_count_q;

  logic             w_sv_rise;
  logic             w_in_stage;
  logic             w_busy;
  logic             w_stage_done;
  logic             w_wdt_expire;

  assign w_sv_rise    = seq_if.samples_valid & ~sv_q;
  assign w_in_stage   = (state_q == ST_FFT) | (state_q == ST_FE) | (state_q == ST_NN);
  assign w_busy       = w_in_stage | (state_q == ST_DONE);
  assign w_stage_done = ((state_q == ST_FFT) & seq_if.fft_done) |
                        ((state_q == ST_FE)  & seq_if.fe_done)  |
                        ((state_q == ST_NN)  & seq_if.nn_done);

`ifdef PIPELINE_SEQ_WDT_EN
  localparam int         WDT_W         = $clog2(WDT_CYCLES);
  localparam logic [1:0] c_STAGE_NONE  = 2'd0;
  localparam logic [1:0] c_STAGE_FFT   = 2'd1;
  localparam logic [1:0] c_STAGE_FE    = 2'd2;
  localparam logic [1:0] c_STAGE_NN    = 2'd3;

  logic [WDT_W-1:0] wdt_q;
  logic             timeout_q;
  logic [1:0]       err_stage_q;
  logic [1:0]       w_stage_code;

  // A done pulse in the expiry cycle takes precedence over the timeout.
  assign w_wdt_expire = seq_if.enable & w_in_stage & ~w_stage_done &
                        (wdt_q == WDT_W'(WDT_CYCLES - 1));

  always_comb begin
    w_stage_code = c_STAGE_NONE;
    case (state_q)
      ST_FFT:  w_stage_code = c_STAGE_FFT;
      ST_FE:   w_stage_code = c_STAGE_FE;
      ST_NN:   w_stage_code = c_STAGE_NN;
      default: w_stage_code = c_STAGE_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_q <= '0;
    end else if ((state_d != state_q) || !w_in_stage) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_q + WDT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q   <= 1'b0;
      err_stage_q <= c_STAGE_NONE;
    end else if (w_wdt_expire) begin
      timeout_q   <= 1'b1;
      err_stage_q <= w_stage_code;
    end else if (seq_if.err_clr) begin
      timeout_q   <= 1'b0;
      err_stage_q <= c_STAGE_NONE;
    end
  end

  assign seq_if.timeout   = timeout_q;
  assign seq_if.err_stage = err_stage_q;
`else
  assign w_wdt_expire     = 1'b0;
  assign seq_if.timeout   = 1'b0;
  assign seq_if.err_stage = 2'd0;
`endif

  always_comb begin
    state_d     = state_q;
    fft_start_d = 1'b0;
    fe_start_d  = 1'b0;
    nn_start_d  = 1'b0;
    // Dropping enable abandons the frame: no starts, no count.
    if (!seq_if.enable && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (seq_if.enable && (seq_if.continuous || seq_if.trigger)) begin
            state_d = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (w_sv_rise) begin
            state_d     = ST_FFT;
            fft_start_d = 1'b1;
          end
        end
        ST_FFT: begin
          if (seq_if.fft_done) begin
            state_d    = ST_FE;
            fe_start_d = 1'b1;
          end else if (w_wdt_expire) begin
            state_d = ST_IDLE;
          end
        end
        ST_FE: begin
          if (seq_if.fe_done) begin
            state_d    = ST_NN;
            nn_start_d = 1'b1;
          end else if (w_wdt_expire) begin
            state_d = ST_IDLE;
          end
        end
        ST_NN: begin
          if (seq_if.nn_done) begin
            state_d = ST_DONE;
          end else if (w_wdt_expire) begin
            state_d = ST_IDLE;
          end
        end
        ST_DONE: begin
          state_d = seq_if.continuous ? ST_ARMED : ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sv_q        <= 1'b0;
      fft_start_q <= 1'b0;
      fe_start_q  <= 1'b0;
      nn_start_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sv_q        <= seq_if.samples_valid;
      fft_start_q <= fft_start_d;
      fe_start_q  <= fe_start_d;
      nn_start_q  <= nn_start_d;
    end
  end

  // Overrun set beats a simultaneous clear; the offending frame is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else if (w_sv_rise && w_busy) begin
      overrun_q <= 1'b1;
    end else if (seq_if.err_clr) begin
      overrun_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count_q <= '0;
    end else if (state_q == ST_DONE) begin
      frame_count_q <= frame_count_q + CNT_W'(1);
    end
  end

  assign seq_if.fft_start   = fft_start_q;
  assign seq_if.fe_start    = fe_start_q;
  assign seq_if.nn_start    = nn_start_q;
  assign seq_if.frame_done  = (state_q == ST_DONE);
  assign seq_if.busy        = w_busy;
  assign seq_if.overrun     = overrun_q;
  assign seq_if.frame_count = frame_count_q;
  assign seq_if.state       = state_q;

endmodule
`default_nettype wire

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Sequencing controller for the SenseEdge inference datapath. It replaces the free-running start-pulse chain between the SPI ADC buffer, FFT engine, feature extractor and NN engine with an explicit per-frame state machine. The block supports single-shot and continuous operation, per-stage watchdog timeouts, overrun detection and a frame counter. It sits in `senseedge_top` between the Wishbone control registers and the datapath `start`/`done` handshakes.

## Interface
Parameters:
- `WDT_CYCLES`, 4096: per-stage watchdog limit in clk cycles (≥2).
- `CNT_W`, 16: frame counter width.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: level; pipeline run enable.
- `continuous` in 1: 1 = re-arm automatically after each frame; 0 = one frame per `trigger`.
- `trigger` in 1: single-cycle pulse; arms one frame in single-shot mode.
- `err_clr` in 1: single-cycle pulse; clears sticky error flags.
- `samples_valid` in 1: from ADC buffer; a rising edge means a frame is ready.
- `fft_done`, `fe_done`, `nn_done` in 1 each: single-cycle stage-completion pulses.
- `fft_start`, `fe_start`, `nn_start` out 1 each: single-cycle stage-start pulses.
- `frame_done` out 1: single-cycle pulse when a frame completes NN.
- `busy` out 1: high in FFT, FE, NN and DONE states.
- `overrun` out 1: sticky; a frame arrived while the pipeline was busy.
- `timeout` out 1: sticky; a stage watchdog expired.
- `err_stage` out 2: stage that timed out (1 = FFT, 2 = FE, 3 = NN, 0 = none).
- `frame_count` out `CNT_W`: number of completed frames.
- `state` out 3: current state encoding, for LA/status readback.

## Operation
States and encodings: IDLE = 0, ARMED = 1, FFT = 2, FE = 3, NN = 4, DONE = 5.

- **IDLE**
  - If `enable` and (`continuous` or `trigger`): go to ARMED.
  - `samples_valid` edges here are ignored and do not set `overrun`.
- **ARMED**
  - A `samples_valid` rising edge (`samples_valid & ~sv_q`, with `sv_q` registered and reset to 0) moves to FFT and issues `fft_start`.
- **FFT / FE / NN**
  - The matching `*_done` pulse moves to the next stage and pulses its `*_start`.
  - `nn_done` moves to DONE.
  - A `*_done` pulse that does not match the current state is ignored.
- **DONE**
  - Lasts one cycle.
  - `frame_done` is high and `frame_count` increments, wrapping from all-ones to 0.
  - Next state is ARMED if `continuous & enable`, otherwise IDLE.
- **Overrun**
  - A `samples_valid` rising edge in FFT, FE, NN or DONE sets `overrun`.
  - That frame is dropped, not queued.
- **Disable**
  - `enable` low in any state except IDLE forces IDLE on the next edge.
  - No further starts are issued, in-flight `*_done` pulses are ignored, and the frame is not counted.
- **Errors**
  - `err_clr` clears `overrun`, `timeout` and `err_stage`.
  - If an error event occurs in the same cycle as `err_clr`, the set wins.
- **Start outputs**
  - All start outputs are registered and never overlap; at most one is high per cycle.

## Timing
- Reset values: every output is 0; `state` = IDLE; `sv_q` = 0; the watchdog counter is 0.
- `samples_valid` rises in cycle N (in ARMED) → `fft_start` is high in N+1 and `state` = FFT from N+1.
- `fft_done` in cycle M → `fe_start` in M+1. `fe_done` in cycle M → `nn_start` in M+1.
- `nn_done` in cycle K → `frame_done` in K+1; `frame_count` shows the new value from K+2.
- Single-shot: `trigger` in cycle T (IDLE, `enable` = 1) → `state` = ARMED in T+1.
- Minimum frame period in continuous mode: 1 + stage latencies + 2 cycles.
- Asserting `rst_n` mid-frame immediately returns the block to reset values, with no start pulses.

## Configuration
- `PIPELINE_SEQ_WDT_EN` defined:
  - A counter clears on every state entry and increments each cycle in FFT, FE and NN.
  - When it reaches `WDT_CYCLES-1` with no matching done: `timeout` is set, `err_stage` is set to the stage code, and the next state is IDLE.
  - In continuous mode with `enable` high, ARMED follows one cycle later.
  - If the done pulse arrives in the same cycle as expiry, the done wins and no timeout occurs.
- `PIPELINE_SEQ_WDT_EN` undefined:
  - No counter is built; `timeout` and `err_stage` are tied to 0.
  - Stages wait indefinitely.

## Test plan
- Continuous mode with stage latencies of 10/5/20 cycles: for each frame the bench checks single start pulses at done+1 and `frame_done` at `nn_done`+1. After 3 frames `frame_count` = 3.
- Single-shot (`continuous` = 0): `trigger` followed by one `samples_valid` edge completes one frame and returns to IDLE. A second `samples_valid` edge without `trigger` issues no `fft_start`.
- `samples_valid` edge while in FE → `overrun` = 1 and the frame completes normally. A subsequent `err_clr` pulse gives `overrun` = 0. `err_clr` coinciding with a new overrun leaves `overrun` = 1.
- `PIPELINE_SEQ_WDT_EN`, `WDT_CYCLES` = 16, `fe_done` withheld → `timeout` = 1 and `err_stage` = 2 after 16 cycles in FE, then IDLE, then ARMED. With `fe_done` arriving exactly at expiry: no timeout.
- `enable` dropped in NN → IDLE next cycle; a late `nn_done` gives no `frame_done` and `frame_count` is unchanged.
- `rst_n` pulsed low mid-FFT → all outputs 0 and `state` = 0 asynchronously; normal operation after release.
